// File: rtl/dot_prod_pkg.sv
// Shared types and saturation limits for the dot-product engine.
package dot_prod_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int LIM_W = 64;

  // Limits are returned in the low w bits of a wide word; callers size-cast to w.
  function automatic logic [LIM_W-1:0] sat_umax(input int w);
    return (64'd1 << w) - 64'd1;
  endfunction

  function automatic logic [LIM_W-1:0] sat_smax(input int w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction

  function automatic logic [LIM_W-1:0] sat_smin(input int w);
    return 64'd1 << (w - 1);
  endfunction

endpackage

// File: rtl/dot_prod_engine_if.sv
// Write/readback/handshake bundle between the front end and the dot-product engine.
interface dot_prod_engine_if #(
  parameter int N     = 4,
  parameter int DW    = 8,
  parameter int ACC_W = 16
);
  localparam int IDX_W = $clog2(N);

  logic             wr_en;
  logic             wr_sel;
  logic [IDX_W-1:0] wr_idx;
  logic [DW-1:0]    wr_data;
  logic             rd_sel;
  logic [IDX_W-1:0] rd_idx;
  logic [DW-1:0]    rd_data;
  logic             is_signed;
  logic             start;
  logic             ready;
  logic             busy;
  logic             done;
  logic             valid;
  logic [ACC_W-1:0] result;
  logic             overflow;

  modport master (
    output wr_en, wr_sel, wr_idx, wr_data, rd_sel, rd_idx, is_signed, start,
    input  rd_data, ready, busy, done, valid, result, overflow
  );

  modport slave (
    input  wr_en, wr_sel, wr_idx, wr_data, rd_sel, rd_idx, is_signed, start,
    output rd_data, ready, busy, done, valid, result, overflow
  );
endinterface

// File: rtl/dot_prod_mac.sv
// Operand-registered multiply-accumulate with sticky overflow.
// Clamping arithmetic is enabled by DOT_PROD_SAT_EN; otherwise results wrap.
module dot_prod_mac
  import dot_prod_pkg::*;
#(
  parameter int DW    = 8,
  parameter int ACC_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear_i,
  input  logic             load_i,
  input  logic             signed_i,
  input  logic [DW-1:0]    a_i,
  input  logic [DW-1:0]    b_i,
  output logic [ACC_W-1:0] acc_o,
  output logic             ovf_o
);
  localparam int EXT_W = ACC_W + 1 - 2 * DW;

  logic [DW-1:0]    a_q, b_q;
  logic             vld_q, mode_q, fresh_q, ovf_q;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [2*DW-1:0]  uprod_s, sprod_s;
  logic [ACC_W-1:0] base_s;
  logic [ACC_W:0]   prod_x_s, base_x_s, sum_s;
  logic             ovf_step_s;

`ifdef DOT_PROD_SAT_EN
  localparam logic [ACC_W-1:0] UMAX = ACC_W'(sat_umax(ACC_W));
  localparam logic [ACC_W-1:0] SMAX = ACC_W'(sat_smax(ACC_W));
  localparam logic [ACC_W-1:0] SMIN = ACC_W'(sat_smin(ACC_W));
`endif

  // One-bit-wider sum: bit ACC_W is the unsigned carry, or the true sign in signed mode.
  always_comb begin
    uprod_s  = {{DW{1'b0}}, a_q} * {{DW{1'b0}}, b_q};
    sprod_s  = $signed({{DW{a_q[DW-1]}}, a_q}) * $signed({{DW{b_q[DW-1]}}, b_q});
    base_s   = fresh_q ? '0 : acc_q;
    prod_x_s = '0;
    base_x_s = '0;
    if (mode_q) begin
      prod_x_s = {{EXT_W{sprod_s[2*DW-1]}}, sprod_s};
      base_x_s = {base_s[ACC_W-1], base_s};
    end else begin
      prod_x_s = {{EXT_W{1'b0}}, uprod_s};
      base_x_s = {1'b0, base_s};
    end
    sum_s      = base_x_s + prod_x_s;
    ovf_step_s = mode_q ? (sum_s[ACC_W] ^ sum_s[ACC_W-1]) : sum_s[ACC_W];
`ifdef DOT_PROD_SAT_EN
    if (ovf_step_s) begin
      if (mode_q) begin
        acc_d = sum_s[ACC_W] ? SMIN : SMAX;
      end else begin
        acc_d = UMAX;
      end
    end else begin
      acc_d = sum_s[ACC_W-1:0];
    end
`else
    acc_d = sum_s[ACC_W-1:0];
`endif
  end

  // Clear only arms a fresh start so the visible accumulator changes solely on accumulate edges.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      vld_q   <= 1'b0;
      mode_q  <= 1'b0;
      fresh_q <= 1'b0;
      ovf_q   <= 1'b0;
      acc_q   <= '0;
    end else begin
      vld_q <= load_i;
      if (load_i) begin
        a_q <= a_i;
        b_q <= b_i;
      end
      if (clear_i) begin
        fresh_q <= 1'b1;
        ovf_q   <= 1'b0;
        mode_q  <= signed_i;
      end else if (vld_q) begin
        fresh_q <= 1'b0;
        acc_q   <= acc_d;
        ovf_q   <= ovf_q | ovf_step_s;
      end
    end
  end

  assign acc_o = acc_q;
  assign ovf_o = ovf_q;
endmodule

// File: rtl/dot_prod_engine.sv
// Dot-product engine top: vector register file, written mask, FSM and fetch counter.
// Optional macro DOT_PROD_SAT_EN selects saturating accumulation inside dot_prod_mac.
module dot_prod_engine
  import dot_prod_pkg::*;
#(
  parameter int N     = 4,
  parameter int DW    = 8,
  parameter int ACC_W = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  dot_prod_engine_if.slave bus
);
  localparam int IDX_W = $clog2(N);
  localparam int CNT_W = IDX_W + 1;
  localparam logic [CNT_W-1:0] N_C = CNT_W'(N);

  state_e           state_q, state_d;
  logic [DW-1:0]    mem_a_q [N];
  logic [DW-1:0]    mem_b_q [N];
  logic [N-1:0]     mask_a_q, mask_b_q;
  logic [CNT_W-1:0] cnt_q;
  logic             done_q;
  logic             ready_s, start_acc_s, fetch_s, finish_s, wr_ok_s;
  logic [DW-1:0]    rd_data_s;
  logic [ACC_W-1:0] acc_s;
  logic             ovf_s;

  assign ready_s = (&mask_a_q) && (&mask_b_q) && (state_q != RUN);
  assign wr_ok_s = bus.wr_en && (state_q != RUN) && !start_acc_s
                   && ({1'b0, bus.wr_idx} < N_C);

  // Next-state and pipeline control.
  always_comb begin
    state_d     = state_q;
    start_acc_s = 1'b0;
    fetch_s     = 1'b0;
    finish_s    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start && ready_s) begin
          start_acc_s = 1'b1;
          state_d     = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (cnt_q < N_C) begin
          fetch_s = 1'b1;
        end else begin
          finish_s = 1'b1;
          state_d  = DONE;
        end
      end
      DONE: begin
        if (bus.start && ready_s) begin
          start_acc_s = 1'b1;
          state_d     = RUN;
        end else if (bus.wr_en) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Vector register file and written mask.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        mem_a_q[i] <= '0;
        mem_b_q[i] <= '0;
      end
      mask_a_q <= '0;
      mask_b_q <= '0;
    end else if (wr_ok_s) begin
      if (bus.wr_sel) begin
        mem_b_q[bus.wr_idx]  <= bus.wr_data;
        mask_b_q[bus.wr_idx] <= 1'b1;
      end else begin
        mem_a_q[bus.wr_idx]  <= bus.wr_data;
        mask_a_q[bus.wr_idx] <= 1'b1;
      end
    end
  end

  // Fetch counter and done pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= finish_s;
      if (start_acc_s) begin
        cnt_q <= '0;
      end else if (fetch_s) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  // Readback returns zero for out-of-range indices.
  always_comb begin
    rd_data_s = '0;
    if ({1'b0, bus.rd_idx} < N_C) begin
      if (bus.rd_sel) begin
        rd_data_s = mem_b_q[bus.rd_idx];
      end else begin
        rd_data_s = mem_a_q[bus.rd_idx];
      end
    end else begin
      rd_data_s = '0;
    end
  end

  dot_prod_mac #(.DW(DW), .ACC_W(ACC_W)) u_mac (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear_i  (start_acc_s),
    .load_i   (fetch_s),
    .signed_i (bus.is_signed),
    .a_i      (mem_a_q[cnt_q[IDX_W-1:0]]),
    .b_i      (mem_b_q[cnt_q[IDX_W-1:0]]),
    .acc_o    (acc_s),
    .ovf_o    (ovf_s)
  );

  assign bus.rd_data  = rd_data_s;
  assign bus.ready    = ready_s;
  assign bus.busy     = (state_q == RUN);
  assign bus.done     = done_q;
  assign bus.valid    = (state_q == DONE);
  assign bus.result   = acc_s;
  assign bus.overflow = ovf_s;
endmodule

// File: tb/tb_dot_prod_engine.sv
// Self-checking bench for dot_prod_engine: directed and random runs against an integer reference model.
module tb_dot_prod_engine;
  localparam int N     = 4;
  localparam int DW    = 8;
  localparam int ACC_W = 16;
  localparam int IDX_W = $clog2(N);

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  logic [DW-1:0] ma [N];
  logic [DW-1:0] mb [N];
  logic [ACC_W-1:0] last_res;

  dot_prod_engine_if #(.N(N), .DW(DW), .ACC_W(ACC_W)) bus ();
  dot_prod_engine #(.N(N), .DW(DW), .ACC_W(ACC_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic sel, input int idx, input logic [DW-1:0] d);
    bus.wr_en   = 1'b1;
    bus.wr_sel  = sel;
    bus.wr_idx  = IDX_W'(idx);
    bus.wr_data = d;
    tick();
    bus.wr_en = 1'b0;
    if (sel) mb[idx] = d;
    else     ma[idx] = d;
  endtask

  task automatic load(input logic [N-1:0][DW-1:0] a, input logic [N-1:0][DW-1:0] b);
    for (int i = 0; i < N; i++) begin
      wr(1'b0, i, a[i]);
      wr(1'b1, i, b[i]);
    end
  endtask

  // Reference: exact integer dot product, checked against the mode's range after every step.
  function automatic void model(input bit sgn, output logic [ACC_W-1:0] r, output logic ov);
    longint acc, p, lo, hi, span;
    span = longint'(1) << ACC_W;
    lo   = sgn ? -(span / 2) : longint'(0);
    hi   = sgn ? (span / 2 - 1) : (span - 1);
    acc  = 0;
    ov   = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (sgn) p = longint'($signed(ma[i])) * longint'($signed(mb[i]));
      else     p = longint'(ma[i]) * longint'(mb[i]);
      acc += p;
      if (acc > hi) begin
        ov = 1'b1;
`ifdef DOT_PROD_SAT_EN
        acc = hi;
`else
        acc -= span;
`endif
      end else if (acc < lo) begin
        ov = 1'b1;
`ifdef DOT_PROD_SAT_EN
        acc = lo;
`else
        acc += span;
`endif
      end
    end
    r = ACC_W'(acc);
  endfunction

  task automatic run(input bit sgn, input string tag);
    logic [ACC_W-1:0] er;
    logic             eo;
    int               bc, dc, dk;
    model(sgn, er, eo);
    bus.is_signed = sgn;
    bus.start     = 1'b1;
    tick();
    bus.start     = 1'b0;
    bus.is_signed = ~sgn;
    bc = bus.busy ? 1 : 0;
    dc = 0;
    dk = 0;
    for (int k = 1; k <= 3 * N; k++) begin
      tick();
      if (bus.busy) bc++;
      if (bus.done) begin
        dc++;
        dk = k;
      end
    end
    chk({tag, "_done_pulses"}, dc, 1);
    chk({tag, "_latency"}, dk, N + 1);
    chk({tag, "_busy_cycles"}, bc, N + 1);
    chk({tag, "_valid"}, bus.valid, 1'b1);
    chk({tag, "_result"}, bus.result, er);
    chk({tag, "_overflow"}, bus.overflow, eo);
    last_res = bus.result;
  endtask

  task automatic wait_done(input bit sgn, input string tag);
    logic [ACC_W-1:0] er;
    logic             eo;
    int               t;
    model(sgn, er, eo);
    t = 0;
    while (!bus.valid && t < 3 * N) begin
      tick();
      t++;
    end
    chk({tag, "_valid"}, bus.valid, 1'b1);
    chk({tag, "_result"}, bus.result, er);
    chk({tag, "_overflow"}, bus.overflow, eo);
  endtask

  initial begin
    int dc;
    logic [N-1:0][DW-1:0] ra, rb;
    bus.wr_en = 1'b0; bus.wr_sel = 1'b0; bus.wr_idx = '0; bus.wr_data = '0;
    bus.rd_sel = 1'b0; bus.rd_idx = '0; bus.is_signed = 1'b0; bus.start = 1'b0;
    for (int i = 0; i < N; i++) begin
      ma[i] = '0;
      mb[i] = '0;
    end
    tick();
    tick();
    chk("rst_ready", bus.ready, 1'b0);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_valid", bus.valid, 1'b0);
    chk("rst_done", bus.done, 1'b0);
    chk("rst_result", bus.result, '0);
    chk("rst_overflow", bus.overflow, 1'b0);
    chk("rst_rd_data", bus.rd_data, '0);
    rst_n = 1'b1;

    // Seven of eight elements written: start must be ignored.
    for (int i = 0; i < N; i++) wr(1'b0, i, DW'(i + 1));
    for (int i = 0; i < N - 1; i++) wr(1'b1, i, DW'(i + 5));
    chk("partial_ready", bus.ready, 1'b0);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("partial_busy", bus.busy, 1'b0);
    tick();
    chk("partial_still_idle", bus.busy | bus.valid, 1'b0);
    wr(1'b1, N - 1, 8'd8);
    chk("full_ready", bus.ready, 1'b1);

    run(1'b0, "u_basic");
    chk("u_basic_const", bus.result, 16'h0046);

    // Write in DONE returns to IDLE, result held.
    wr(1'b0, 0, 8'd1);
    chk("done_wr_valid", bus.valid, 1'b0);
    chk("done_wr_hold", bus.result, last_res);

    // Write attempted during RUN is dropped.
    bus.is_signed = 1'b0;
    bus.start = 1'b1;
    tick();
    bus.start   = 1'b0;
    bus.wr_en   = 1'b1; bus.wr_sel = 1'b0; bus.wr_idx = IDX_W'(1); bus.wr_data = 8'hAA;
    tick();
    bus.wr_en   = 1'b0;
    bus.rd_sel  = 1'b0; bus.rd_idx = IDX_W'(1);
    #1;
    chk("run_wr_dropped", bus.rd_data, ma[1]);
    wait_done(1'b0, "u_rerun");

    load({N{8'hFF}}, {N{8'hFF}});
    run(1'b0, "u_ff");
`ifdef DOT_PROD_SAT_EN
    chk("u_ff_const", bus.result, 16'hFFFF);
`else
    chk("u_ff_const", bus.result, 16'hF804);
`endif

    load({8'h04, 8'hFD, 8'h02, 8'hFF}, {N{8'h05}});
    run(1'b1, "s_mix");
    chk("s_mix_const", bus.result, 16'h000A);

    load({N{8'h80}}, {N{8'h80}});
    run(1'b1, "s_min");
`ifdef DOT_PROD_SAT_EN
    chk("s_min_const", bus.result, 16'h7FFF);
`else
    chk("s_min_const", bus.result, 16'h0000);
`endif

    // Start and write in the same cycle: write is dropped, run proceeds.
    bus.is_signed = 1'b1;
    bus.start = 1'b1;
    bus.wr_en = 1'b1; bus.wr_sel = 1'b0; bus.wr_idx = '0; bus.wr_data = 8'h11;
    tick();
    bus.start = 1'b0;
    bus.wr_en = 1'b0;
    bus.rd_sel = 1'b0; bus.rd_idx = '0;
    #1;
    chk("start_wr_dropped", bus.rd_data, ma[0]);
    chk("start_wr_busy", bus.busy, 1'b1);
    wait_done(1'b1, "start_wr");

    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < N; i++) begin
        ra[i] = DW'($urandom);
        rb[i] = DW'($urandom);
      end
      load(ra, rb);
      run(1'(r % 2), "rand");
    end

    // Reset two cycles into a run aborts it silently.
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("abort_busy", bus.busy, 1'b0);
    chk("abort_result", bus.result, '0);
    chk("abort_ready", bus.ready, 1'b0);
    chk("abort_overflow", bus.overflow, 1'b0);
    dc = 0;
    for (int k = 0; k < 3 * N; k++) begin
      tick();
      if (bus.done) dc++;
    end
    chk("abort_no_done", dc, 0);
    bus.rd_sel = 1'b1; bus.rd_idx = IDX_W'(2);
    #1;
    chk("abort_mem_cleared", bus.rd_data, '0);
    for (int i = 0; i < N; i++) begin
      ma[i] = '0;
      mb[i] = '0;
      ra[i] = DW'($urandom);
      rb[i] = DW'($urandom);
    end
    load(ra, rb);
    run(1'b0, "after_abort");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/dot_prod_engine.md
Name: dot_prod_engine

Overview:
- Parametrised dot-product engine for two N-element vectors A and B, with DW-bit elements and an ACC_W-bit accumulator.
- Provides a vector register file with write and readback, a start/busy/done handshake, and a two-stage operand-fetch then multiply-accumulate pipeline.
- Supports an unsigned/signed mode and sticky overflow.
- Sits between the switch/button front end and the 7-segment/LED display logic, and replaces the fixed 4x8-bit MAC path.

Parameters:
- N, 4: vector length, N >= 2.
- DW, 8: element width in bits.
- ACC_W, 16: accumulator/result width; ACC_W >= 2*DW is required.
- IDX_W, $clog2(N): index width (derived; not overridden).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  synchronous active-low reset.
- wr_en  in  1  write strobe for one element.
- wr_sel  in  1  write target: 0 = A, 1 = B.
- wr_idx  in  IDX_W  write element index.
- wr_data  in  DW  write data.
- rd_sel  in  1  readback vector select: 0 = A, 1 = B.
- rd_idx  in  IDX_W  readback index.
- rd_data  out  DW  combinational readback of the selected element.
- is_signed  in  1  mode; sampled only when start is accepted.
- start  in  1  request to compute.
- ready  out  1  all 2N elements written and state != RUN.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse when the result becomes valid.
- valid  out  1  result valid; held high in DONE.
- result  out  ACC_W  dot product.
- overflow  out  1  sticky overflow flag for the current computation.

Behaviour:
- Reset (rst_n low at a clock edge):
  - State goes to IDLE.
  - All elements are cleared to 0 and the written mask is cleared.
  - result = 0, overflow = 0, done = 0, valid = 0, busy = 0, ready = 0.
  - Reset during RUN aborts the computation with no done pulse.
- States:
  - IDLE -> RUN when start && ready.
  - RUN -> DONE after N fetch cycles plus 1 drain cycle.
  - DONE -> RUN on start (ready is still 1).
  - DONE -> IDLE on wr_en; valid clears and result holds its old value.
- Writes:
  - Accepted in IDLE and DONE: element[wr_sel][wr_idx] <= wr_data, and the corresponding mask bit is set.
  - Ignored in RUN.
  - If start is accepted in the same cycle as wr_en, the write is dropped.
  - If wr_idx >= N (non-power-of-2 N), the write is ignored.
- Start:
  - Ignored unless ready is 1.
  - On the accepting edge (edge 0): accumulator <= 0, overflow <= 0, fetch index <= 0, mode latched from is_signed.
- Pipeline:
  - RUN edges 1..N: operand registers load A[k] and B[k].
  - Edges 2..N+1: accumulator += product of the operand registers.
  - At edge N+1: state becomes DONE, done = 1 for one cycle, valid = 1.
  - busy is high from after edge 0 until edge N+1.
  - Start-to-done latency is N+1 cycles.
- Arithmetic, unsigned mode:
  - Product is 2*DW unsigned, zero-extended to ACC_W+1 bits.
  - overflow |= carry out of bit ACC_W-1.
- Arithmetic, signed mode:
  - Operands are two's complement; product is 2*DW signed, sign-extended.
  - overflow |= signed overflow, i.e. the true sum lies outside [-2^(ACC_W-1), 2^(ACC_W-1)-1].
- Default result (feature off): wraps modulo 2^ACC_W.
- result updates only at accumulate edges and is stable in DONE.

Optional Feature:
- Macro: DOT_PROD_SAT_EN.
- Defined: each accumulate step clamps to the mode's range.
  - Unsigned clamps to 2^ACC_W-1.
  - Signed clamps to 2^(ACC_W-1)-1 or -2^(ACC_W-1).
  - overflow is still set when a clamp occurs.
  - Later steps continue from the clamped value.
- Undefined: wrap-around arithmetic, no clamp logic.

Decomposition:
- Package dot_prod_pkg contains:
  - state enum {IDLE, RUN, DONE}.
  - Saturation limit constants/functions for unsigned and signed, parametrised by width.
- Sub-module dot_prod_mac: operand-registered multiply-accumulate.
  - Inputs: clear, enable, operands, signed mode.
  - Outputs: acc, sticky overflow.
  - Holds all wrap/saturation logic under DOT_PROD_SAT_EN.
- The top level holds the register file, written mask, FSM and fetch counter.

Test Plan:
- Unsigned, defaults: A = [1,2,3,4], B = [5,6,7,8], start.
  -> result = 0x0046, overflow = 0, done is a single pulse exactly 5 cycles after the start edge, busy is high for 5 cycles.
- Unsigned, all elements 0xFF.
  -> without SAT: result = 0xF804, overflow = 1.
  -> with DOT_PROD_SAT_EN: result = 0xFFFF, overflow = 1.
- Signed: A = [0xFF,0x02,0xFD,0x04], B = [5,5,5,5].
  -> result = 0x000A, overflow = 0.
- Signed, all elements 0x80.
  -> overflow = 1.
  -> without SAT: result = 0x0000.
  -> with SAT: result = 0x7FFF.
- Only 7 of 8 elements written, then start.
  -> ready = 0, start ignored, state stays IDLE.
  -> Write the last element: ready = 1 next cycle.
  -> A wr_en during RUN does not change rd_data.
- rst_n low 2 cycles after start.
  -> busy = 0, result = 0, ready = 0, no done pulse.
  -> A re-run after rewriting the vectors gives the correct result.
